// File: rtl/split_guard_pkg.sv
//------------------------------------------------------------------------------
// split_guard_pkg
//   Shared types and constants for the registered address-decoding splitter:
//   FSM state encoding, err_code values and bus width helpers.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package split_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE   = 2'b00;
  localparam err_code_t ERR_DECODE = 2'b01;
  localparam err_code_t ERR_TMO    = 2'b10;

  // Request is {valid, addr, wdata, wstrb}; one strobe bit per data byte.
  function automatic int bus_req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Response is {rdata, ready}.
  function automatic int bus_resp_w(input int data_w);
    return data_w + 1;
  endfunction

  // Counter width able to hold 0..limit; at least one bit so a disabled
  // timeout still yields a legal vector.
  function automatic int cnt_w(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/split_guard_if.sv
//------------------------------------------------------------------------------
// split_guard_if
//   Bundle of the master-side and slave-side bus vectors around split_guard.
//   Ports (signals):
//     m_req   master request {valid, addr, wdata, wstrb}
//     m_resp  master response {rdata, ready}
//     s_req   N_SLAVES packed slave requests, slave i in slice i
//     s_resp  N_SLAVES packed slave responses, slave i in slice i
//   Modports:
//     master  the environment: drives m_req and the slave responses
//     slave   the splitter: consumes m_req/s_resp, drives m_resp/s_req
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface split_guard_if #(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) ();
  import split_guard_pkg::*;

  localparam int SEL_W   = $clog2(N_SLAVES);
  localparam int DADDR_W = ADDR_W - SEL_W;
  localparam int MREQ_W  = bus_req_w(ADDR_W, DATA_W);
  localparam int SREQ_W  = bus_req_w(DADDR_W, DATA_W);
  localparam int RESP_W  = bus_resp_w(DATA_W);

  logic [MREQ_W-1:0]          m_req;
  logic [RESP_W-1:0]          m_resp;
  logic [N_SLAVES*SREQ_W-1:0] s_req;
  logic [N_SLAVES*RESP_W-1:0] s_resp;

  modport master (output m_req, output s_resp, input m_resp, input s_req);
  modport slave  (input m_req, input s_resp, output m_resp, output s_req);

endinterface

`default_nettype wire

// File: rtl/bus_timeout.sv
//------------------------------------------------------------------------------
// bus_timeout
//   Saturating up-counter with synchronous clear, load and enable, plus an
//   expired flag raised while the count equals i_limit.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     i_clear      force count to zero (highest priority)
//     i_load       load i_load_val
//     i_enable     increment by one (saturates at all-ones, never wraps)
//     i_load_val   value for i_load
//     i_limit      compare value for o_expired
//     o_expired    count == i_limit
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_timeout #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_clear,
  input  wire logic             i_load,
  input  wire logic             i_enable,
  input  wire logic [WIDTH-1:0] i_load_val,
  input  wire logic [WIDTH-1:0] i_limit,
  output logic                  o_expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_enable && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == i_limit);

endmodule

`default_nettype wire

// File: rtl/split_guard.sv
//------------------------------------------------------------------------------
// split_guard
//   Registered address-decoding bus splitter. The route to the addressed slave
//   is held until that slave answers, so the response always comes from the
//   slave that took the request. Unmapped addresses and silent slaves produce
//   an ERR_DATA response instead of a hang.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     bus          split_guard_if.slave: m_req/s_resp in, m_resp/s_req out
//     err          one-cycle pulse with an error response
//     err_code     00 none, 01 decode, 10 timeout; held to next accept
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module split_guard
  import split_guard_pkg::*;
#(
  parameter int               N_SLAVES = 4,
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter int               TIMEOUT  = 256,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  split_guard_if.slave   bus,
  output logic           err,
  output err_code_t      err_code
);

  localparam int c_SEL_W   = $clog2(N_SLAVES);
  localparam int c_DADDR_W = ADDR_W - c_SEL_W;
  localparam int c_WSTRB_W = DATA_W / 8;
  localparam int c_MREQ_W  = bus_req_w(ADDR_W, DATA_W);
  localparam int c_SREQ_W  = bus_req_w(c_DADDR_W, DATA_W);
  localparam int c_RESP_W  = bus_resp_w(DATA_W);
  localparam int c_TMO_W   = cnt_w(TIMEOUT);
  localparam logic [c_TMO_W-1:0] c_TMO_LIMIT =
    c_TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Master request fields
  logic                 w_m_valid;
  logic [ADDR_W-1:0]    w_m_addr;
  logic [DATA_W-1:0]    w_m_wdata;
  logic [c_WSTRB_W-1:0] w_m_wstrb;
  logic [c_SEL_W-1:0]   w_sel;
  logic                 w_sel_ok;

  assign w_m_valid = bus.m_req[c_MREQ_W-1];
  assign w_m_addr  = bus.m_req[c_MREQ_W-2 -: ADDR_W];
  assign w_m_wdata = bus.m_req[c_WSTRB_W +: DATA_W];
  assign w_m_wstrb = bus.m_req[c_WSTRB_W-1:0];
  assign w_sel     = w_m_addr[ADDR_W-1 -: c_SEL_W];
  // N_SLAVES need not be a power of two, so the top select codes may be holes.
  assign w_sel_ok  = (int'(w_sel) < N_SLAVES);

  // FSM and captured request/response
  state_t                r_state;
  logic [c_SEL_W-1:0]    r_sel;
  logic [c_DADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [c_WSTRB_W-1:0]  r_wstrb;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  err_code_t             r_err_code;

  // Response of the selected slave; others are never looked at.
  logic                  w_sel_ready;
  logic [DATA_W-1:0]     w_sel_rdata;

  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (r_sel == c_SEL_W'(i)) begin
        w_sel_ready = bus.s_resp[i*c_RESP_W];
        w_sel_rdata = bus.s_resp[i*c_RESP_W+1 +: DATA_W];
      end
    end
  end

  // Slave requests come purely from registers; only the routed slice is live.
  logic [N_SLAVES*c_SREQ_W-1:0] w_s_req;

  always_comb begin
    w_s_req = '0;
    if (r_state == ST_BUSY) begin
      for (int i = 0; i < N_SLAVES; i++) begin
        if (r_sel == c_SEL_W'(i)) begin
          w_s_req[i*c_SREQ_W +: c_SREQ_W] = {1'b1, r_addr, r_wdata, r_wstrb};
        end
      end
    end
  end

  assign bus.s_req  = w_s_req;
  assign bus.m_resp = {r_rdata, (r_state == ST_RESP)};
  assign err        = (r_state == ST_RESP) && r_err;
  assign err_code   = r_err_code;

  // Timeout: count is held at zero outside BUSY, so the first BUSY cycle
  // sees 0 and the last permitted cycle sees TIMEOUT-1.
  logic w_tmo_clear;
  logic w_tmo_en;
  logic w_tmo_expired;
  logic w_tmo_hit;

  assign w_tmo_clear = (r_state != ST_BUSY);
  assign w_tmo_en    = (r_state == ST_BUSY) && !w_sel_ready;
  assign w_tmo_hit   = (TIMEOUT != 0) && w_tmo_expired;

  bus_timeout #(
    .WIDTH (c_TMO_W)
  ) u_tmo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_tmo_clear),
    .i_load     (1'b0),
    .i_enable   (w_tmo_en),
    .i_load_val ({c_TMO_W{1'b0}}),
    .i_limit    (c_TMO_LIMIT),
    .o_expired  (w_tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_m_valid) begin
            if (w_sel_ok) begin
              r_sel      <= w_sel;
              r_addr     <= w_m_addr[c_DADDR_W-1:0];
              r_wdata    <= w_m_wdata;
              r_wstrb    <= w_m_wstrb;
              r_err      <= 1'b0;
              r_err_code <= ERR_NONE;
              r_state    <= ST_BUSY;
            end else begin
              r_rdata    <= ERR_DATA;
              r_err      <= 1'b1;
              r_err_code <= ERR_DECODE;
              r_state    <= ST_RESP;
            end
          end
        end
        ST_BUSY: begin
          // Ready in the final permitted cycle beats the timeout.
          if (w_sel_ready) begin
            r_rdata <= w_sel_rdata;
            r_err   <= 1'b0;
            r_state <= ST_RESP;
          end else if (w_tmo_hit) begin
            r_rdata    <= ERR_DATA;
            r_err      <= 1'b1;
            r_err_code <= ERR_TMO;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          // m valid is deliberately not sampled here: the master may still be
          // holding the request it just got an answer for.
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_split_guard.sv
//------------------------------------------------------------------------------
// tb_split_guard
//   Directed testbench for split_guard: a 4-slave instance (TIMEOUT=8) and a
//   3-slave instance for the unmapped-select case.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_split_guard;
  import split_guard_pkg::*;

  localparam int SRW = 67;  // slave request slice: 1+30+32+4
  localparam int RW  = 33;  // response slice

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  split_guard_if #(.N_SLAVES(4), .ADDR_W(32), .DATA_W(32)) if4 ();
  split_guard_if #(.N_SLAVES(3), .ADDR_W(32), .DATA_W(32)) if3 ();

  logic      err4, err3;
  err_code_t ec4, ec3;

  split_guard #(.N_SLAVES(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8),
                .ERR_DATA(32'hDEADBEEF)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4), .err(err4), .err_code(ec4));

  split_guard #(.N_SLAVES(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8),
                .ERR_DATA(32'hDEADBEEF)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3), .err(err3), .err_code(ec3));

  function automatic logic [68:0] mk_req(input logic v, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] s);
    return {v, a, d, s};
  endfunction

  function automatic logic [SRW-1:0] slc(input logic [4*SRW-1:0] v, input int i);
    return v[i*SRW +: SRW];
  endfunction

  task automatic set_resp(input int i, input logic rdy, input logic [31:0] d);
    if4.s_resp[i*RW +: RW] = {d, rdy};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [SRW-1:0] s;
    if4.m_req = '0; if4.s_resp = '0; if3.m_req = '0; if3.s_resp = '0;
    rst_n = 1'b0;
    tick(); tick();
    n_vec++; if (if4.m_resp !== 33'd0) begin n_err++; $display("FAIL rst_mresp: got %h want 0", if4.m_resp); end
    n_vec++; if (if4.s_req !== '0) begin n_err++; $display("FAIL rst_sreq: got %h want 0", if4.s_req); end
    n_vec++; if (err4 !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err4); end
    n_vec++; if (ec4 !== ERR_NONE || ec3 !== ERR_NONE) begin n_err++; $display("FAIL rst_errcode: got %b/%b want 00", ec4, ec3); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    s = slc(if4.s_req, 0);
    n_vec++; if (s !== '0) begin n_err++; $display("FAIL idle_sreq0: got %h want 0", s); end
  endtask

  task automatic test_read();
    logic [SRW-1:0] s;
    if4.m_req = mk_req(1'b1, 32'h8000_0010, 32'h0, 4'h0);
    tick();  // cycle 1
    s = slc(if4.s_req, 2);
    n_vec++; if (s[66] !== 1'b1 || s[65:36] !== 30'h10) begin n_err++; $display("FAIL rd_sreq2: got v=%b a=%h want v=1 a=10", s[66], s[65:36]); end
    n_vec++; if ((if4.s_req & ~({4*SRW{1'b0}} | ({{(3*SRW){1'b0}}, {SRW{1'b1}}} << (2*SRW)))) !== '0) begin
      n_err++; $display("FAIL rd_others: got %h want other slices 0", if4.s_req); end
    n_vec++; if (if4.m_resp[0] !== 1'b0) begin n_err++; $display("FAIL rd_early: got ready %b want 0", if4.m_resp[0]); end
    set_resp(2, 1'b1, 32'h1234_5678);
    tick();  // cycle 2
    n_vec++; if (if4.m_resp !== {32'h1234_5678, 1'b1}) begin n_err++; $display("FAIL rd_mresp: got %h want %h", if4.m_resp, {32'h1234_5678, 1'b1}); end
    n_vec++; if (if4.s_req !== '0 || err4 !== 1'b0) begin n_err++; $display("FAIL rd_resp_state: got sreq %h err %b want 0/0", if4.s_req, err4); end
    if4.m_req = '0; if4.s_resp = '0;
    tick();  // cycle 3, idle
    n_vec++; if (if4.m_resp !== {32'h1234_5678, 1'b0}) begin n_err++; $display("FAIL rd_hold: got %h want %h", if4.m_resp, {32'h1234_5678, 1'b0}); end
  endtask

  task automatic test_decode();
    if3.m_req = mk_req(1'b1, 32'hC000_0000, 32'h0, 4'h0);
    tick();  // cycle 1
    n_vec++; if (if3.m_resp !== {32'hDEAD_BEEF, 1'b1}) begin n_err++; $display("FAIL dec_mresp: got %h want %h", if3.m_resp, {32'hDEAD_BEEF, 1'b1}); end
    n_vec++; if (err3 !== 1'b1 || ec3 !== ERR_DECODE) begin n_err++; $display("FAIL dec_err: got err %b code %b want 1/01", err3, ec3); end
    n_vec++; if (if3.s_req !== '0) begin n_err++; $display("FAIL dec_sreq: got %h want 0", if3.s_req); end
    if3.m_req = '0;
    tick();
    n_vec++; if (err3 !== 1'b0 || ec3 !== ERR_DECODE || if3.m_resp[0] !== 1'b0) begin
      n_err++; $display("FAIL dec_after: got err %b code %b rdy %b want 0/01/0", err3, ec3, if3.m_resp[0]); end
  endtask

  // rdy_cyc: BUSY cycle in which slave 1 answers (0 = never).
  task automatic test_timeout(input int rdy_cyc, input logic [31:0] exp_data,
                              input logic exp_err, input err_code_t exp_code);
    int vc = 0; int rc = 0;
    logic [32:0] resp = '0; logic e = 1'b0; err_code_t c_seen = ERR_NONE;
    logic [SRW-1:0] s;
    if4.m_req = mk_req(1'b1, 32'h4000_0020, 32'h0, 4'h0);
    tick();
    for (int c = 1; c <= 20 && rc == 0; c++) begin
      if (if4.m_resp[0] === 1'b1) begin
        rc = c; resp = if4.m_resp; e = err4; c_seen = ec4;
        if4.m_req = '0; if4.s_resp = '0;
      end else begin
        s = slc(if4.s_req, 1);
        if (s[66] === 1'b1) vc++;
        set_resp(1, (c == rdy_cyc), (c == rdy_cyc) ? 32'hCAFE_F00D : 32'h0);
        tick();
      end
    end
    n_vec++; if (rc !== 9) begin n_err++; $display("FAIL tmo_lat(%0d): got ready cycle %0d want 9", rdy_cyc, rc); end
    n_vec++; if (vc !== 8) begin n_err++; $display("FAIL tmo_svalid(%0d): got %0d cycles want 8", rdy_cyc, vc); end
    n_vec++; if (resp !== {exp_data, 1'b1} || e !== exp_err || c_seen !== exp_code) begin
      n_err++; $display("FAIL tmo_resp(%0d): got %h err %b code %b want %h %b %b", rdy_cyc, resp, e, c_seen, {exp_data, 1'b1}, exp_err, exp_code); end
    tick();
  endtask

  task automatic test_write_once();
    int waits = 0; int writes = 0; int vcyc = 0; int nrdy = 0; logic drop = 1'b0;
    logic [SRW-1:0] s;
    if4.m_req = mk_req(1'b1, 32'h0000_0044, 32'hA5A5_5A5A, 4'hF);
    tick();
    for (int c = 1; c <= 12; c++) begin
      if (drop) if4.m_req = '0;
      s = slc(if4.s_req, 0);
      if (s[66] === 1'b1) begin
        vcyc++;
        if (c == 1) begin
          n_vec++; if (s[65:0] !== {30'h44, 32'hA5A5_5A5A, 4'hF}) begin
            n_err++; $display("FAIL wr_fields: got %h want %h", s[65:0], {30'h44, 32'hA5A5_5A5A, 4'hF}); end
        end
        if (waits == 3) begin
          set_resp(0, 1'b1, 32'h0BAD_CAFE);
          if (s[3:0] != 4'h0) writes++;
          waits = 0;
        end else begin
          waits++; set_resp(0, 1'b0, 32'h0);
        end
      end else begin
        set_resp(0, 1'b0, 32'h0);
      end
      if (if4.m_resp[0] === 1'b1) begin
        nrdy++;
        n_vec++; if (if4.m_resp[32:1] !== 32'h0BAD_CAFE) begin n_err++; $display("FAIL wr_rdata: got %h want 0badcafe", if4.m_resp[32:1]); end
        drop = 1'b1;  // valid stays up through the ready cycle, drops next
      end
      tick();
    end
    if4.m_req = '0; if4.s_resp = '0;
    n_vec++; if (writes !== 1 || vcyc !== 4 || nrdy !== 1) begin
      n_err++; $display("FAIL wr_once: got writes %0d valid %0d readys %0d want 1/4/1", writes, vcyc, nrdy); end
  endtask

  task automatic test_reset_mid();
    logic [SRW-1:0] s;
    if4.m_req = mk_req(1'b1, 32'h4000_0000, 32'h0, 4'h0);
    tick();
    s = slc(if4.s_req, 1);
    n_vec++; if (s[66] !== 1'b1) begin n_err++; $display("FAIL rm_busy: got valid %b want 1", s[66]); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (if4.s_req !== '0 || if4.m_resp !== 33'd0) begin
      n_err++; $display("FAIL rm_async: got sreq %h mresp %h want 0/0", if4.s_req, if4.m_resp); end
    if4.m_req = '0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    if4.m_req = mk_req(1'b1, 32'h4000_0008, 32'h0, 4'h0);
    tick();
    s = slc(if4.s_req, 1);
    n_vec++; if (s[66] !== 1'b1 || s[65:36] !== 30'h8) begin n_err++; $display("FAIL rm_req: got v=%b a=%h want 1/8", s[66], s[65:36]); end
    set_resp(1, 1'b1, 32'h5555_AAAA);
    tick();
    n_vec++; if (if4.m_resp !== {32'h5555_AAAA, 1'b1}) begin n_err++; $display("FAIL rm_resp: got %h want %h", if4.m_resp, {32'h5555_AAAA, 1'b1}); end
    if4.m_req = '0; if4.s_resp = '0;
    tick();
  endtask

  task automatic test_spurious();
    logic [SRW-1:0] s;
    if4.m_req = mk_req(1'b1, 32'h4000_000C, 32'h0, 4'h0);
    tick();  // cycle 1
    set_resp(3, 1'b1, 32'h3333_3333);
    tick();  // cycle 2
    s = slc(if4.s_req, 1);
    n_vec++; if (if4.m_resp[0] !== 1'b0 || s[66] !== 1'b1) begin
      n_err++; $display("FAIL spur_ignored: got ready %b s1valid %b want 0/1", if4.m_resp[0], s[66]); end
    set_resp(1, 1'b1, 32'h1111_1111);
    tick();  // cycle 3
    n_vec++; if (if4.m_resp !== {32'h1111_1111, 1'b1}) begin n_err++; $display("FAIL spur_resp: got %h want %h", if4.m_resp, {32'h1111_1111, 1'b1}); end
    if4.m_req = '0; if4.s_resp = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [SRW-1:0] s;
    if4.m_req = mk_req(1'b1, 32'h0000_0100, 32'h0, 4'h0);
    tick();  // cycle 1
    set_resp(0, 1'b1, 32'h1111_0000);
    tick();  // cycle 2: response, next request presented immediately
    n_vec++; if (if4.m_resp !== {32'h1111_0000, 1'b1}) begin n_err++; $display("FAIL b2b_first: got %h want %h", if4.m_resp, {32'h1111_0000, 1'b1}); end
    if4.s_resp = '0;
    if4.m_req = mk_req(1'b1, 32'hC000_0004, 32'h0, 4'h0);
    tick();  // cycle 3: idle, request sampled at the end of it
    n_vec++; if (if4.s_req !== '0) begin n_err++; $display("FAIL b2b_gap: got %h want 0", if4.s_req); end
    tick();  // cycle 4
    s = slc(if4.s_req, 3);
    n_vec++; if (s[66] !== 1'b1 || s[65:36] !== 30'h4) begin n_err++; $display("FAIL b2b_second: got v=%b a=%h want 1/4", s[66], s[65:36]); end
    set_resp(3, 1'b1, 32'h3333_0001);
    tick();  // cycle 5
    n_vec++; if (if4.m_resp !== {32'h3333_0001, 1'b1}) begin n_err++; $display("FAIL b2b_resp: got %h want %h", if4.m_resp, {32'h3333_0001, 1'b1}); end
    if4.m_req = '0; if4.s_resp = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_decode();
    test_timeout(0, 32'hDEAD_BEEF, 1'b1, ERR_TMO);
    test_timeout(8, 32'hCAFE_F00D, 1'b0, ERR_NONE);
    test_write_once();
    test_reset_mid();
    test_spurious();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/split_guard.md
# split_guard

Registered address-decoding bus splitter: one native-bus master fanned out to N_SLAVES slaves, selected by the address MSBs. Unlike the combinational splitter, it holds the route until the addressed slave responds, so the response always comes from the slave that took the request. Unmapped addresses and slaves that never answer get an error response instead of a hang. It sits between a CPU/DMA master and the peripheral address map.

## Interface

Parameters:
- N_SLAVES, 4: slave count, ≥2. Need not be a power of two.
- ADDR_W, 32: master address width.
- DATA_W, 32: data width; WSTRB_W = DATA_W/8.
- TIMEOUT, 256: maximum BUSY cycles per transaction; 0 disables the timeout.
- ERR_DATA, 32'hDEADBEEF: rdata returned on any error.
- Derived: SEL_W = $clog2(N_SLAVES); DADDR_W = ADDR_W-SEL_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m_req  in  1+ADDR_W+DATA_W+WSTRB_W  master request {valid, addr, wdata, wstrb}, valid at the MSB.
- m_resp  out  DATA_W+1  master response {rdata, ready}.
- s_req  out  N_SLAVES*(1+DADDR_W+DATA_W+WSTRB_W)  slave requests; slave i occupies slice i; address is addr[DADDR_W-1:0].
- s_resp  in  N_SLAVES*(DATA_W+1)  slave responses {rdata, ready}.
- err  out  1  one-cycle pulse coinciding with an error response.
- err_code  out  2  00 none, 01 decode error, 10 timeout; held until the next accepted request.

## Operation

- Slave index sel = addr[ADDR_W-1 -: SEL_W].
- Master protocol: holds valid and fields stable until it sees ready. A write is wstrb≠0.
- FSM states: IDLE, BUSY, RESP.
- IDLE, m valid=1, sel<N_SLAVES:
  - capture addr/wdata/wstrb/sel into registers; clear err_code; go BUSY.
- IDLE, m valid=1, sel≥N_SLAVES (decode error):
  - load rdata=ERR_DATA, err_code=01; go RESP; no slave is touched.
- BUSY:
  - s_req[sel] driven from the captured fields with valid=1; every other slice is all-zero.
  - s_resp[sel].ready=1: capture its rdata; go RESP.
  - Timeout: tmo_cnt starts at 0 on the first BUSY cycle and increments each cycle without ready. If tmo_cnt==TIMEOUT-1 with no ready, go RESP with rdata=ERR_DATA, err_code=10.
  - A ready in that final cycle wins over the timeout.
  - Ready from any non-selected slave is ignored.
- RESP:
  - m_resp.ready=1 with the captured rdata for exactly one cycle; err=1 if this is an error response.
  - m valid is ignored in RESP, so the old request is not re-issued. Go IDLE.
- Outside RESP, m_resp.ready=0 and m_resp.rdata holds its last value.

## Timing

- Reset (rst_n low, any cycle, including mid-transaction):
  - state=IDLE; all s_req=0; m_resp=0; err=0; err_code=00; tmo_cnt=0.
  - The abandoned slave sees its valid drop with no handshake.
- Latency, slave answering in the same cycle as its valid:
  - m valid sampled at edge 0; s valid high in cycle 1; m ready in cycle 2.
  - Minimum master-visible latency is 2 cycles. Each extra slave wait cycle adds 1.
- Decode error: m ready with ERR_DATA in cycle 1.
- Timeout: s valid high for exactly TIMEOUT cycles, then m ready with ERR_DATA the cycle after.
- Slave valid drops in the same cycle m ready is asserted (RESP).
- Back-to-back transactions: a new request is sampled in the IDLE cycle after RESP, giving a 3-cycle issue interval minimum.
- Slave inputs feed only registers; no combinational path from s_resp to m_resp or from m_req to s_req.
- tmo_cnt width is $clog2(TIMEOUT+1) and never wraps.

## Structure

- interconnect.vh gains the widths BUS_REQ_W(ADDR_W, DATA_W) and BUS_RESP_W(DATA_W), plus the err_code constants ERR_NONE/ERR_DECODE/ERR_TMO.
- Request/response slicing reuses the existing get_req/get_resp macros.
- One sub-module: bus_timeout, a loadable counter with clear/enable and an expired flag, reusable by other guarded interconnect blocks.
- FSM and datapath registers live in split_guard.

## Test plan

- N_SLAVES=4, ADDR_W=32: read addr 0x8000_0010, slave 2 ready in cycle 1 with rdata 0x1234_5678.
  - Expect: s_req[2] addr=0x10 valid in cycle 1; m ready with 0x1234_5678 in cycle 2; other slices zero.
- N_SLAVES=3: addr 0xC000_0000 (sel=3).
  - Expect: no slave valid; m ready with 0xDEADBEEF in cycle 1; err pulse; err_code=01.
- TIMEOUT=8, slave 1 never ready.
  - Expect: s valid for 8 cycles; m ready with ERR_DATA in cycle 9; err_code=10.
  - Repeat with ready in BUSY cycle 8: slave data returned, no error.
- Write wstrb=4'hF to slave 0 with ready after 3 wait cycles; master keeps valid high one extra cycle after ready.
  - Expect: exactly one write seen by slave 0; no re-issue.
- rst_n low during BUSY.
  - Expect: outputs zero asynchronously; after release, a new read completes normally.
- Slave 3 asserts spurious ready while slave 1 is selected.
  - Expect: ignored; completion only on slave 1 ready.
